// File: rtl/rv32i_types.sv
`default_nettype none
// rv32i_types -- shared RV32I word/field types and fetch-stage definitions | rev 1.0
package rv32i_types;

   typedef logic [31:0] rv32i_word;
   typedef logic [4:0]  rv32i_reg;

   typedef enum logic [6:0] {
      OP_LUI   = 7'b0110111,
      OP_AUIPC = 7'b0010111,
      OP_JAL   = 7'b1101111,
      OP_JALR  = 7'b1100111,
      OP_BR    = 7'b1100011,
      OP_LOAD  = 7'b0000011,
      OP_STORE = 7'b0100011,
      OP_IMM   = 7'b0010011,
      OP_REG   = 7'b0110011,
      OP_CSR   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

   // addi x0, x0, 0
   localparam rv32i_word NOP_INSTR = 32'h0000_0013;

   function automatic rv32i_word align_pc(input rv32i_word addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// fetch_unit_if -- imem request/response and decode-side signals of the fetch stage | rev 1.0
interface fetch_unit_if;
   import rv32i_types::*;

   logic        imem_read;
   rv32i_word   imem_address;
   logic        imem_resp;
   rv32i_word   imem_rdata;

   logic        stall;
   logic        redirect;
   rv32i_word   redirect_pc;

   logic        if_valid;
   rv32i_word   if_pc;
   rv32i_word   if_instr;
   rv32i_opcode if_opcode;
   logic [2:0]  if_funct3;
   logic [6:0]  if_funct7;
   rv32i_reg    if_rs1;
   rv32i_reg    if_rs2;
   rv32i_reg    if_rd;

   modport master (
      output imem_read, imem_address,
      input  imem_resp, imem_rdata,
      input  stall, redirect, redirect_pc,
      output if_valid, if_pc, if_instr, if_opcode,
      output if_funct3, if_funct7, if_rs1, if_rs2, if_rd
   );

   modport slave (
      input  imem_read, imem_address,
      output imem_resp, imem_rdata,
      output stall, redirect, redirect_pc,
      input  if_valid, if_pc, if_instr, if_opcode,
      input  if_funct3, if_funct7, if_rs1, if_rs2, if_rd
   );

endinterface
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// fetch_skid_buf -- single-entry {pc, instr} buffer catching a response decode cannot take | rev 1.0
module fetch_skid_buf
   import rv32i_types::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      load_i,
   input  logic      clear_i,
   input  logic      unload_i,
   input  rv32i_word pc_i,
   input  rv32i_word instr_i,
   output logic      valid_o,
   output rv32i_word pc_o,
   output rv32i_word instr_o
);

   logic      valid_q, valid_d;
   rv32i_word pc_q, pc_d;
   rv32i_word instr_q, instr_d;

   // Clear dominates so a flush can never resurrect a stale entry.
   always_comb begin
      valid_d = valid_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      if (clear_i) begin
         valid_d = 1'b0;
      end else if (load_i) begin
         valid_d = 1'b1;
         pc_d    = pc_i;
         instr_d = instr_i;
      end else if (unload_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         valid_q <= valid_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign valid_o = valid_q;
   assign pc_o    = pc_q;
   assign instr_o = instr_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit -- RV32I instruction fetch: PC, imem handshake, skid buffer and IF/ID register | rev 1.0
module fetch_unit
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0060,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic         clk,
   input  logic         rst,
   fetch_unit_if.master bus
);

   fetch_state_t state_q, state_d;
   rv32i_word    pc_q, pc_d;
   rv32i_word    req_addr_q, req_addr_d;
   logic         if_valid_q, if_valid_d;
   rv32i_word    if_pc_q, if_pc_d;
   rv32i_word    if_instr_q, if_instr_d;

   logic         w_ld;
   rv32i_word    w_redirect_tgt;
   rv32i_word    w_instr;
   logic         w_skid_load;
   logic         w_skid_clear;
   logic         w_skid_unload;
   logic         w_skid_valid;
   rv32i_word    w_skid_pc;
   rv32i_word    w_skid_instr;

   assign w_ld           = !bus.stall || !if_valid_q;
   assign w_redirect_tgt = align_pc(bus.redirect_pc);

   // A request stays open in DROP on the address it was issued with.
   assign bus.imem_read    = !rst && (state_q != HOLD);
   assign bus.imem_address = (state_q == DROP) ? req_addr_q : pc_q;

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .load_i   (w_skid_load),
      .clear_i  (w_skid_clear),
      .unload_i (w_skid_unload),
      .pc_i     (pc_q),
      .instr_i  (bus.imem_rdata),
      .valid_o  (w_skid_valid),
      .pc_o     (w_skid_pc),
      .instr_o  (w_skid_instr)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      req_addr_d    = req_addr_q;
      if_valid_d    = if_valid_q;
      if_pc_d       = if_pc_q;
      if_instr_d    = if_instr_q;
      w_skid_load   = 1'b0;
      w_skid_clear  = 1'b0;
      w_skid_unload = 1'b0;

      unique case (state_q)
         FETCH: begin
            if (bus.redirect) begin
               pc_d       = w_redirect_tgt;
               if_valid_d = 1'b0;
               if (!bus.imem_resp) begin
                  req_addr_d = pc_q;
                  state_d    = DROP;
               end
            end else if (bus.imem_resp) begin
               if (w_ld) begin
                  if_pc_d    = pc_q;
                  if_instr_d = bus.imem_rdata;
                  if_valid_d = 1'b1;
               end else begin
                  w_skid_load = 1'b1;
                  state_d     = HOLD;
               end
               pc_d = pc_q + 32'd4;
            end else if (!bus.stall) begin
               if_valid_d = 1'b0;
            end
         end

         HOLD: begin
            if (bus.redirect) begin
               w_skid_clear = 1'b1;
               if_valid_d   = 1'b0;
               pc_d         = w_redirect_tgt;
               state_d      = FETCH;
            end else if (!bus.stall && w_skid_valid) begin
               if_pc_d       = w_skid_pc;
               if_instr_d    = w_skid_instr;
               if_valid_d    = 1'b1;
               w_skid_unload = 1'b1;
               state_d       = FETCH;
            end
         end

         DROP: begin
            if_valid_d = 1'b0;
            if (bus.redirect) begin
               pc_d = w_redirect_tgt;
            end
            if (bus.imem_resp) begin
               state_d = FETCH;
            end
         end

         default: begin
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= FETCH;
         pc_q       <= RESET_PC;
         req_addr_q <= '0;
         if_valid_q <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= NOP_INSTR;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         if_valid_q <= if_valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end

   assign w_instr       = if_valid_q ? if_instr_q : NOP_INSTR;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_pc     = if_pc_q;
   assign bus.if_instr  = w_instr;
   assign bus.if_opcode = rv32i_opcode'(w_instr[6:0]);
   assign bus.if_funct3 = w_instr[14:12];
   assign bus.if_funct7 = w_instr[31:25];
   assign bus.if_rs1    = w_instr[19:15];
   assign bus.if_rs2    = w_instr[24:20];
   assign bus.if_rd     = w_instr[11:7];

`ifndef SYNTHESIS
   // No request is open while holding the skid entry, so a response here is a memory bug.
   a_no_resp_in_hold: assert property (@(posedge clk) disable iff (rst)
      !(bus.imem_resp && (state_q == HOLD)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit -- randomized stall/redirect/latency/reset stimulus against a queue-based fetch model | rev 1.0
module tb_fetch_unit;
   import rv32i_types::*;

   localparam logic [31:0] RST_PC = 32'h0000_0060;
   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam int          N_CYC  = 3000;

   logic clk = 1'b0;
   logic rst;

   fetch_unit_if bus ();

   fetch_unit #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         if (n_errors <= 40)
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
   endfunction

   // Reference model: where the next fetch goes, whether an abandoned request is
   // still open, fetched-but-not-delivered words, and the instruction decode sees.
   logic [31:0] m_pc;
   logic        m_stale;
   logic [31:0] m_stale_addr;
   logic [31:0] m_pending[$];
   logic        m_ifv;
   logic [31:0] m_ifpc;
   int          delivered = 0;

   task automatic model_reset();
      m_pc         = RST_PC;
      m_stale      = 1'b0;
      m_stale_addr = '0;
      m_pending.delete();
      m_ifv        = 1'b0;
      m_ifpc       = '0;
   endtask

   task automatic model_step();
      logic ld;
      if (rst) begin
         model_reset();
      end else begin
         ld = !bus.stall || !m_ifv;
         if (bus.redirect) begin
            m_ifv = 1'b0;
            if (m_pending.size() != 0) begin
               m_pending.delete();
            end else if (m_stale) begin
               if (bus.imem_resp) m_stale = 1'b0;
            end else if (!bus.imem_resp) begin
               m_stale      = 1'b1;
               m_stale_addr = m_pc;
            end
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
         end else if (m_pending.size() != 0) begin
            if (!bus.stall) begin
               m_ifpc = m_pending.pop_front();
               m_ifv  = 1'b1;
               delivered++;
            end
         end else if (m_stale) begin
            if (bus.imem_resp) m_stale = 1'b0;
         end else if (bus.imem_resp) begin
            if (ld) begin
               m_ifpc = m_pc;
               m_ifv  = 1'b1;
               delivered++;
            end else begin
               m_pending.push_back(m_pc);
            end
            m_pc = m_pc + 32'd4;
         end else if (!bus.stall) begin
            m_ifv = 1'b0;
         end
      end
   endtask

   task automatic compare_outputs();
      logic        exp_read;
      logic [31:0] exp_instr;
      logic [6:0]  op;
      exp_read  = !rst && (m_pending.size() == 0);
      exp_instr = m_ifv ? mem_word(m_ifpc) : NOP;
      op        = bus.if_opcode;
      check_eq("imem_read", 32'(bus.imem_read), 32'(exp_read));
      if (exp_read)
         check_eq("imem_address", bus.imem_address, m_stale ? m_stale_addr : m_pc);
      check_eq("if_valid", 32'(bus.if_valid), 32'(m_ifv));
      check_eq("if_pc", bus.if_pc, m_ifpc);
      check_eq("if_instr", bus.if_instr, exp_instr);
      check_eq("fields",
               {op, bus.if_funct3, bus.if_funct7, bus.if_rs1, bus.if_rs2, bus.if_rd},
               {exp_instr[6:0], exp_instr[14:12], exp_instr[31:25],
                exp_instr[19:15], exp_instr[24:20], exp_instr[11:7]});
   endtask

   // Memory: accepts an open request, answers after 0..lat_hi extra cycles.
   logic        mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;

   task automatic memory_step(input int lat_hi);
      if (rst) begin
         bus.imem_resp = 1'b0;
         mem_busy      = 1'b0;
      end else if (mem_busy) begin
         if (mem_wait == 0) begin
            bus.imem_resp  = 1'b1;
            bus.imem_rdata = mem_word(mem_addr);
            mem_busy       = 1'b0;
         end else begin
            mem_wait--;
            bus.imem_resp = 1'b0;
         end
      end else begin
         bus.imem_resp = 1'b0;
         if (bus.imem_read) begin
            mem_busy = 1'b1;
            mem_addr = bus.imem_address;
            mem_wait = int'($urandom_range(0, lat_hi));
         end
      end
   endtask

   function automatic logic [31:0] pick_target();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0200;
         1:       return 32'h0000_0203;
         2:       return 32'hFFFF_FFF8;
         3:       return 32'hFFFF_FFFC;
         4:       return 32'h0000_0070;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      int stall_pct;
      int redir_pct;
      int rst_pct;
      int lat_hi;
      rst             = 1'b1;
      bus.stall       = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.imem_resp   = 1'b0;
      bus.imem_rdata  = '0;
      mem_busy        = 1'b0;
      mem_addr        = '0;
      mem_wait        = 0;
      model_reset();

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         compare_outputs();

         if (cyc < 60) begin
            stall_pct = 0;  redir_pct = 0;  rst_pct = 0; lat_hi = 0;
         end else if (cyc < 700) begin
            stall_pct = 40; redir_pct = 0;  rst_pct = 0; lat_hi = 2;
         end else if (cyc < 1600) begin
            stall_pct = 30; redir_pct = 15; rst_pct = 0; lat_hi = 3;
         end else begin
            stall_pct = 35; redir_pct = 25; rst_pct = 2; lat_hi = 3;
         end

         rst             = (cyc < 2) || (int'($urandom_range(0, 99)) < rst_pct);
         bus.stall       = int'($urandom_range(0, 99)) < stall_pct;
         bus.redirect    = int'($urandom_range(0, 99)) < redir_pct;
         bus.redirect_pc = pick_target();
         #1;
         memory_step(lat_hi);
         model_step();
      end

      check_eq("progress", 32'(delivered > 100), 32'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
